// File: rtl/rlc_adc_pkg.sv
// Shared types, widths and the config-word builder for the RLC ADC capture front end.
package rlc_adc_pkg;

  localparam int unsigned ADC_BITS = 12;
  localparam int unsigned CFG_BITS = 6;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CH_W     = 3;
  // 12 SCK periods = 24 SCK edges per read
  localparam int unsigned EDGE_CNT = 2 * ADC_BITS;
  localparam int unsigned EDGE_W   = $clog2(EDGE_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVST,
    ST_CONV_WAIT,
    ST_SHIFT,
    ST_DONE
  } adc_state_e;

  // Word handed to the PIO in_port
  typedef struct packed {
    logic                overrun;
    logic [CH_W-1:0]     channel;
    logic [ADC_BITS-1:0] result;
  } sample_word_t;

  // LTC2308 DIN word: {S/D, O/S, S1, S0, UNI, SLP}, single-ended unipolar, awake
  function automatic logic [CFG_BITS-1:0] build_cfg(input logic [CH_W-1:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

endpackage

// File: rtl/rlc_adc_capture_if.sv
// SPI/CONVST pin bundle between the capture block (master) and the ADC (slave).
interface rlc_adc_capture_if;
  logic adc_convst;
  logic adc_sck;
  logic adc_mosi;
  logic adc_miso;

  modport master (output adc_convst, output adc_sck, output adc_mosi, input adc_miso);
  modport slave  (input adc_convst, input adc_sck, input adc_mosi, output adc_miso);
endinterface

// File: rtl/rlc_adc_sck_gen.sv
// SCK divider: toggles every CLK_DIV cycles while enabled, flags the edge about to happen.
module rlc_adc_sck_gen
  import rlc_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  output logic              o_sck,
  output logic              o_rise_c,
  output logic              o_fall_c,
  output logic [EDGE_W-1:0] o_edge_cnt
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  r_div;
  logic              r_sck;
  logic [EDGE_W-1:0] r_edge_cnt;
  logic              w_tick;

  // A tick means the SCK register toggles on this clock edge
  assign w_tick     = i_en && (r_div == DIV_W'(CLK_DIV - 1));
  assign o_rise_c   = w_tick && !r_sck;
  assign o_fall_c   = w_tick && r_sck;
  assign o_sck      = r_sck;
  assign o_edge_cnt = r_edge_cnt;

  // Divider, SCK level and edge count; everything parks at zero when disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_sck      <= 1'b0;
      r_edge_cnt <= '0;
    end else if (!i_en) begin
      r_div      <= '0;
      r_sck      <= 1'b0;
      r_edge_cnt <= '0;
    end else if (w_tick) begin
      r_div      <= '0;
      r_sck      <= ~r_sck;
      r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
    end else begin
      r_div      <= r_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/rlc_adc_capture.sv
// Periodic LTC2308-style SPI ADC sampler producing the RLC game's 16-bit PIO input word.
module rlc_adc_capture
  import rlc_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned CONVST_CYCLES = 2,
  parameter int unsigned CONV_CYCLES   = 80,
  parameter int unsigned SAMPLE_PERIOD = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CH_W-1:0]   channel,
  input  logic              overrun_clr,
  rlc_adc_capture_if.master spi,
  output logic [DATA_W-1:0] data_out,
  output logic              sample_valid,
  output logic              busy
);

  localparam int unsigned PER_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned WAIT_MAX = (CONV_CYCLES > CONVST_CYCLES) ? CONV_CYCLES : CONVST_CYCLES;
  localparam int unsigned CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  adc_state_e          r_state;
  logic [PER_W-1:0]    r_period_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CH_W-1:0]     r_ch;
  logic [CFG_BITS-1:0] r_cfg_sh;
  logic [ADC_BITS-1:0] r_shift;
  logic                r_convst;
  logic                r_mosi;
  logic                r_busy;
  logic                r_valid;
  sample_word_t        r_data;
  logic                r_pending;
  logic                r_overrun;

  logic                w_trigger;
  logic                w_shift_en;
  logic                w_sck;
  logic                w_rise;
  logic                w_fall;
  logic [EDGE_W-1:0]   w_edge_cnt;
  logic                w_shift_last;

  assign w_trigger    = enable && (r_period_cnt == PER_W'(SAMPLE_PERIOD - 1));
  assign w_shift_en   = (r_state == ST_SHIFT);
  assign w_shift_last = w_fall && (w_edge_cnt == EDGE_W'(EDGE_CNT - 1));

  rlc_adc_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk        (clk),
    .rst        (reset),
    .i_en       (w_shift_en),
    .o_sck      (w_sck),
    .o_rise_c   (w_rise),
    .o_fall_c   (w_fall),
    .o_edge_cnt (w_edge_cnt)
  );

  // Sample-period counter; parked at zero while sampling is disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period_cnt <= '0;
    end else if (!enable || w_trigger) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + PER_W'(1);
    end
  end

  // Conversion sequencer with trigger deferral, overrun tracking and result publishing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ch      <= '0;
      r_cfg_sh  <= '0;
      r_shift   <= '0;
      r_convst  <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      // one deferred trigger is remembered; a second one while deferred is lost
      if (!enable) begin
        r_pending <= 1'b0;
      end else if (w_trigger && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end

      // set has priority over a simultaneous clear
      if (w_trigger && (r_state != ST_IDLE) && r_pending) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (enable && (w_trigger || r_pending)) begin
            r_state   <= ST_CONVST;
            r_convst  <= 1'b1;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_ch      <= channel;
            r_cfg_sh  <= build_cfg(channel);
            r_pending <= 1'b0;
          end
        end
        ST_CONVST: begin
          if (r_cnt == CNT_W'(CONVST_CYCLES - 1)) begin
            r_state  <= ST_CONV_WAIT;
            r_convst <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        ST_CONV_WAIT: begin
          if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
            r_state  <= ST_SHIFT;
            r_mosi   <= r_cfg_sh[CFG_BITS-1];
            r_cfg_sh <= {r_cfg_sh[CFG_BITS-2:0], 1'b0};
          end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (w_rise) begin
            r_shift <= {r_shift[ADC_BITS-2:0], spi.adc_miso};
          end
          if (w_fall) begin
            r_mosi   <= r_cfg_sh[CFG_BITS-1];
            r_cfg_sh <= {r_cfg_sh[CFG_BITS-2:0], 1'b0};
          end
          // last SCK fall: all 12 bits are in, publish as DONE is entered
          if (w_shift_last) begin
            r_state <= ST_DONE;
            r_mosi  <= 1'b0;
            r_data  <= {r_overrun, r_ch, r_shift};
            r_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi.adc_convst = r_convst;
  assign spi.adc_sck    = w_sck;
  assign spi.adc_mosi   = r_mosi;
  assign data_out       = r_data;
  assign sample_valid   = r_valid;
  assign busy           = r_busy;

endmodule

// File: tb/tb_rlc_adc_capture.sv
// Bench for rlc_adc_capture: two instances (normal period and a short period that forces overruns).
module tb_rlc_adc_capture;

  typedef struct packed {
    logic [15:0] data;
    logic [5:0]  cfg;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        enable      [2];
  logic [2:0]  channel     [2];
  logic        overrun_clr [2];
  logic [15:0] data_out    [2];
  logic        sample_valid[2];
  logic        busy        [2];
  logic        sck_w       [2];
  logic        convst_w    [2];
  logic        mosi_w      [2];
  logic [11:0] adc_word    [2];

  exp_t exp_q [2][$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [11:0] words    [8] = '{12'h000, 12'hFFF, 12'h801, 12'h7FE, 12'h123, 12'h456, 12'h9AB, 12'hCDE};
  logic [15:0] exp_data [8] = '{16'h0000, 16'h1FFF, 16'h2801, 16'h37FE, 16'h4123, 16'h5456, 16'h69AB, 16'h7CDE};
  logic [5:0]  cfg_tab  [8] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                                6'b101010, 6'b111010, 6'b101110, 6'b111110};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rlc_adc_capture_if u_if ();
    logic [11:0] sh;
    logic [5:0]  cfg_cap;
    int unsigned rises;

    rlc_adc_capture #(
      .CLK_DIV       (2),
      .CONVST_CYCLES (2),
      .CONV_CYCLES   (10),
      .SAMPLE_PERIOD ((g == 0) ? 200 : 40)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable[g]),
      .channel      (channel[g]),
      .overrun_clr  (overrun_clr[g]),
      .spi          (u_if.master),
      .data_out     (data_out[g]),
      .sample_valid (sample_valid[g]),
      .busy         (busy[g])
    );

    assign u_if.adc_miso = sh[11];
    assign sck_w[g]      = u_if.adc_sck;
    assign convst_w[g]   = u_if.adc_convst;
    assign mosi_w[g]     = u_if.adc_mosi;

    // ADC output: load result at CONVST, next bit after every SCK fall
    always @(posedge u_if.adc_convst or negedge u_if.adc_sck) begin
      if (u_if.adc_convst) sh = adc_word[g];
      else                 sh = {sh[10:0], 1'b0};
    end

    // ADC input: capture the first 6 DIN bits on SCK rises
    always @(posedge u_if.adc_sck or posedge u_if.adc_convst) begin
      if (u_if.adc_convst) begin
        rises   = 0;
        cfg_cap = '0;
      end else begin
        if (rises < 6) cfg_cap[3'(5 - rises)] = u_if.adc_mosi;
        rises++;
      end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
      exp_t e;
      if (!reset && sample_valid[g]) begin
        if (exp_q[g].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid inst%0d: got data 0x%h expected no sample", g, data_out[g]);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("data_out inst%0d", g), 32'(data_out[g]), 32'(e.data));
          chk($sformatf("mosi_cfg inst%0d", g), 32'(cfg_cap), 32'(e.cfg));
        end
      end
    end
  end

  task automatic push(input int g, input logic [15:0] d, input logic [5:0] c);
    exp_t e;
    e.data = d;
    e.cfg  = c;
    exp_q[g].push_back(e);
  endtask

  task automatic wait_busy(input int g, input logic lvl, input int limit, output int t);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy[g] !== lvl && n < limit);
    t = cyc;
    chk($sformatf("wait_busy%0d inst%0d", lvl, g), 32'(busy[g]), 32'(lvl));
  endtask

  task automatic wait_valid(input int g, input int limit, output int t);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (sample_valid[g] !== 1'b1 && n < limit);
    t = cyc;
    chk($sformatf("wait_valid inst%0d", g), 32'(sample_valid[g]), 32'd1);
  endtask

  task automatic wait_drain(input int g, input int limit);
    int n;
    n = 0;
    while (exp_q[g].size() != 0 && n < limit) begin @(negedge clk); n++; end
    chk($sformatf("drain inst%0d", g), 32'(exp_q[g].size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1, t2, tv, tv2, t3, tmp, act, r, n;
    logic prev;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      enable[i] = 1'b0; channel[i] = 3'd0; overrun_clr[i] = 1'b0; adc_word[i] = 12'h000;
    end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst data_out",   32'(data_out[0]), 32'd0);
    chk("rst busy",       32'(busy[0]), 32'd0);
    chk("rst sck",        32'(sck_w[0]), 32'd0);
    chk("rst convst",     32'(convst_w[0]), 32'd0);
    chk("rst mosi",       32'(mosi_w[0]), 32'd0);
    chk("rst valid",      32'(sample_valid[0]), 32'd0);
    reset = 1'b0;

    // idle with enable low: nothing moves
    act = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        if (busy[g] || convst_w[g] || sck_w[g] || mosi_w[g] || sample_valid[g] || data_out[g] != 16'h0) act++;
    end
    chk("idle activity", 32'(act), 32'd0);

    // basic sample: channel 3, result A5C, latency and period
    channel[0] = 3'd3; adc_word[0] = 12'hA5C;
    push(0, 16'h3A5C, 6'b110110);
    push(0, 16'h3A5C, 6'b110110);
    enable[0] = 1'b1;
    wait_busy(0, 1'b1, 300, t1);
    wait_valid(0, 100, tv);
    chk("busy_to_valid latency", 32'(tv - t1), 32'd60);
    wait_busy(0, 1'b0, 10, tmp);
    wait_busy(0, 1'b1, 300, t2);
    chk("sample period", 32'(t2 - t1), 32'd200);
    wait_drain(0, 100);
    wait_busy(0, 1'b0, 10, tmp);
    repeat (5) @(negedge clk);
    chk("data_out held", 32'(data_out[0]), 32'h3A5C);

    // channel map, channel input scrambled mid-conversion
    for (int i = 0; i < 8; i++) begin
      channel[0]  = 3'(i);
      adc_word[0] = words[i];
      push(0, exp_data[i], cfg_tab[i]);
      wait_busy(0, 1'b1, 300, tmp);
      repeat (3) @(negedge clk);
      channel[0] = 3'(i) ^ 3'b101;
      wait_busy(0, 1'b0, 100, tmp);
    end
    wait_drain(0, 10);
    enable[0] = 1'b0;

    // overrun on the short-period instance
    channel[1] = 3'd2; adc_word[1] = 12'h3C5;
    push(1, 16'h23C5, 6'b100110);
    push(1, 16'hA3C5, 6'b100110);
    push(1, 16'h23C5, 6'b100110);
    enable[1] = 1'b1;
    wait_busy(1, 1'b1, 100, t1);
    wait_valid(1, 100, tv);
    wait_busy(1, 1'b1, 10, t2);
    chk("pending start gap 1", 32'(t2 - tv), 32'd2);
    wait_valid(1, 100, tv2);
    wait_busy(1, 1'b1, 10, t3);
    chk("pending start gap 2", 32'(t3 - tv2), 32'd2);
    overrun_clr[1] = 1'b1;
    enable[1]      = 1'b0;
    @(negedge clk);
    overrun_clr[1] = 1'b0;
    wait_busy(1, 1'b0, 100, tmp);
    wait_drain(1, 10);

    // enable dropped 5 cycles into SHIFT
    channel[0] = 3'd6; adc_word[0] = 12'h5A5;
    push(0, 16'h65A5, 6'b101110);
    enable[0] = 1'b1;
    wait_busy(0, 1'b1, 300, tmp);
    repeat (17) @(negedge clk);
    enable[0] = 1'b0;
    wait_busy(0, 1'b0, 100, tmp);
    wait_drain(0, 10);
    act = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (convst_w[0] || busy[0]) act++;
    end
    chk("activity after enable drop", 32'(act), 32'd0);
    chk("data_out after enable drop", 32'(data_out[0]), 32'h65A5);

    // reset after 7 SCK rises
    channel[0] = 3'd5; adc_word[0] = 12'h7E1;
    enable[0] = 1'b1;
    wait_busy(0, 1'b1, 300, tmp);
    r = 0; n = 0; prev = sck_w[0];
    while (r < 7 && n < 200) begin
      @(negedge clk);
      n++;
      if (sck_w[0] && !prev) r++;
      prev = sck_w[0];
    end
    chk("sck rises before reset", 32'(r), 32'd7);
    reset = 1'b1;
    #1;
    chk("midreset sck",      32'(sck_w[0]), 32'd0);
    chk("midreset convst",   32'(convst_w[0]), 32'd0);
    chk("midreset data_out", 32'(data_out[0]), 32'd0);
    chk("midreset busy",     32'(busy[0]), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(0, 16'h57E1, 6'b111010);
    wait_drain(0, 400);
    enable[0] = 1'b0;
    wait_busy(0, 1'b0, 10, tmp);
    repeat (20) @(negedge clk);

    chk("final queue inst0", 32'(exp_q[0].size()), 32'd0);
    chk("final queue inst1", 32'(exp_q[1].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
